// File: rtl/apb_master.sv
// APB3 bridge: latches a single-cycle CPU request, decodes the peripheral window,
// runs SETUP/ACCESS on the selected slave and returns a one-cycle ready/err pulse.
module apb_master #(
    parameter int          NSLV    = 4,
    parameter logic [31:0] BASE    = 32'h1000_0000,
    parameter int          TIMEOUT = 16
) (
    input  logic               PCLK,
    input  logic               PRESET,
    input  logic               transfer,
    input  logic               write,
    input  logic [31:0]        addr,
    input  logic [31:0]        wdata,
    output logic [31:0]        rdata,
    output logic               ready,
    output logic               err,
    output logic [31:0]        PADDR,
    output logic               PWRITE,
    output logic [31:0]        PWDATA,
    output logic               PENABLE,
    output logic [NSLV-1:0]    PSEL,
    input  logic [NSLV*32-1:0] PRDATA,
    input  logic [NSLV-1:0]    PREADY
);

    localparam int CW = $clog2(TIMEOUT) + 1;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, ERR} state_t;

    state_t          state, state_nxt;
    logic [NSLV-1:0] sel, sel_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;

    logic [19:0]     page_off;
    logic            hit;
    logic [NSLV-1:0] dec_sel;
    logic            slv_ready;
    logic [31:0]     slv_rdata;
    logic            timed_out;

    // Window decode: unsigned subtraction makes addresses below BASE wrap to large offsets.
    always_comb begin
        page_off = addr[31:12] - BASE[31:12];
        hit      = (page_off < 20'(NSLV));
        dec_sel  = '0;
        for (int i = 0; i < NSLV; i++) begin
            if (page_off == 20'(i)) dec_sel[i] = 1'b1;
        end
    end

    // Only the latched slave contributes; all other PREADY/PRDATA are ignored.
    always_comb begin
        slv_ready = 1'b0;
        slv_rdata = '0;
        for (int i = 0; i < NSLV; i++) begin
            if (sel[i]) begin
                slv_ready = PREADY[i];
                slv_rdata = PRDATA[32*i +: 32];
            end
        end
    end

    assign timed_out = (cnt == CW'(TIMEOUT - 1));

    always_comb begin
        state_nxt = state;
        sel_nxt   = sel;
        cnt_nxt   = cnt;
        PSEL      = '0;
        PENABLE   = 1'b0;
        ready     = 1'b0;
        err       = 1'b0;
        rdata     = '0;
        case (state)
            IDLE: begin
                if (transfer) begin
                    if (hit) begin
                        state_nxt = SETUP;
                        sel_nxt   = dec_sel;
                        cnt_nxt   = '0;
                    end else begin
                        state_nxt = ERR;
                        sel_nxt   = '0;
                    end
                end
            end
            SETUP: begin
                PSEL      = sel;
                state_nxt = ACCESS;
            end
            ACCESS: begin
                PSEL    = sel;
                PENABLE = 1'b1;
                // A ready arriving on the last allowed cycle wins over the timeout.
                if (slv_ready) begin
                    ready     = 1'b1;
                    rdata     = slv_rdata;
                    state_nxt = IDLE;
                end else if (timed_out) begin
                    ready     = 1'b1;
                    err       = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            ERR: begin
                ready     = 1'b1;
                err       = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state  <= IDLE;
            sel    <= '0;
            cnt    <= '0;
            PADDR  <= '0;
            PWRITE <= 1'b0;
            PWDATA <= '0;
        end else begin
            state <= state_nxt;
            sel   <= sel_nxt;
            cnt   <= cnt_nxt;
            if (state == IDLE && transfer) begin
                PADDR  <= addr;
                PWRITE <= write;
                PWDATA <= wdata;
            end
        end
    end

endmodule

// File: tb/tb_apb_master.sv
// Scoreboard bench for apb_master: directed transfers against behavioural slaves,
// expected completions queued at issue and checked by an independent monitor.
module tb_apb_master;

    logic         PCLK = 1'b0;
    logic         PRESET = 1'b1;
    logic         transfer = 1'b0;
    logic         write = 1'b0;
    logic [31:0]  addr = '0;
    logic [31:0]  wdata = '0;
    logic [31:0]  rdata;
    logic         ready;
    logic         err;
    logic [31:0]  PADDR;
    logic         PWRITE;
    logic [31:0]  PWDATA;
    logic         PENABLE;
    logic [3:0]   PSEL;
    logic [127:0] PRDATA;
    logic [3:0]   PREADY;

    apb_master #(.NSLV(4), .BASE(32'h1000_0000), .TIMEOUT(16)) dut (
        .PCLK(PCLK), .PRESET(PRESET), .transfer(transfer), .write(write),
        .addr(addr), .wdata(wdata), .rdata(rdata), .ready(ready), .err(err),
        .PADDR(PADDR), .PWRITE(PWRITE), .PWDATA(PWDATA), .PENABLE(PENABLE),
        .PSEL(PSEL), .PRDATA(PRDATA), .PREADY(PREADY)
    );

    always #5 PCLK = ~PCLK;

    // Slave models. mode: 0 registered ready, 1 combinational ready, 2 never ready,
    // 3 ready on the 16th ACCESS cycle, 4 PREADY stuck high.
    logic [2:0]  mode  [4];
    logic [31:0] sdata [4];
    logic [3:0]  preg = '0;
    int          acc [4];

    always_ff @(posedge PCLK) begin
        for (int i = 0; i < 4; i++) begin
            if (PSEL[i] && PENABLE) begin
                preg[i] <= ~preg[i];
                acc[i]  <= acc[i] + 1;
            end else begin
                preg[i] <= 1'b0;
                acc[i]  <= 0;
            end
        end
    end

    always_comb begin
        PREADY = '0;
        PRDATA = '0;
        for (int i = 0; i < 4; i++) begin
            PRDATA[32*i +: 32] = sdata[i];
            case (mode[i])
                3'd0: PREADY[i] = preg[i];
                3'd1: PREADY[i] = PSEL[i] & PENABLE;
                3'd3: PREADY[i] = PSEL[i] & PENABLE & (acc[i] == 15);
                3'd4: PREADY[i] = 1'b1;
                default: PREADY[i] = 1'b0;
            endcase
        end
    end

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic [31:0] paddr;
        logic        pwrite;
        logic [31:0] pwdata;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;
    int   ready_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every ready pulse must match the oldest queued expectation.
    always @(negedge PCLK) begin
        if (!PRESET) begin
            if (ready) begin
                ready_cnt++;
                if (q.size() == 0) begin
                    chk("unexpected_ready", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("sb_rdata",  rdata,  e.rdata);
                    chk("sb_err",    32'(err),    32'(e.err));
                    chk("sb_paddr",  PADDR,  e.paddr);
                    chk("sb_pwrite", 32'(PWRITE), 32'(e.pwrite));
                    chk("sb_pwdata", PWDATA, e.pwdata);
                end
            end else begin
                chk("idle_rdata_err", {rdata[31:1], rdata[0] | err}, 32'd0);
            end
        end
    end

    // Drives transfer for exactly one cycle (cycle n); returns just after the n/n+1 edge.
    task automatic start(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input bit push, input logic [31:0] er, input logic ee);
        exp_t e;
        @(posedge PCLK); #1;
        transfer = 1'b1; write = w; addr = a; wdata = d;
        if (push) begin
            e.rdata = er; e.err = ee; e.paddr = a; e.pwrite = w; e.pwdata = d;
            q.push_back(e);
        end
        @(posedge PCLK); #1;
        transfer = 1'b0;
    endtask

    task automatic settle(input int n);
        repeat (n) @(negedge PCLK);
        chk("queue_drained", q.size(), 32'd0);
    endtask

    int rc0;

    initial begin
        for (int i = 0; i < 4; i++) begin
            mode[i]  = 3'd0;
            sdata[i] = 32'hDEAD_0000 | 32'(i);
        end
        repeat (3) @(posedge PCLK);
        #1;
        chk("rst_psel",    32'(PSEL), 32'd0);
        chk("rst_penable", 32'(PENABLE), 32'd0);
        chk("rst_paddr",   PADDR, 32'd0);
        chk("rst_pwdata",  PWDATA, 32'd0);
        chk("rst_pwrite",  32'(PWRITE), 32'd0);
        chk("rst_ready",   32'(ready), 32'd0);
        chk("rst_err",     32'(err), 32'd0);
        chk("rst_rdata",   rdata, 32'd0);
        PRESET = 1'b0;

        // Write to slave 0 with registered PREADY
        sdata[0] = 32'h0;
        start(1'b1, 32'h1000_0000, 32'h0000_00FF, 1, 32'h0, 1'b0);
        @(negedge PCLK);
        chk("w_psel_n1",    32'(PSEL), 32'h1);
        chk("w_penable_n1", 32'(PENABLE), 32'd0);
        chk("w_pwdata",     PWDATA, 32'h0000_00FF);
        chk("w_pwrite",     32'(PWRITE), 32'd1);
        @(negedge PCLK);
        chk("w_psel_n2",    32'(PSEL), 32'h1);
        chk("w_penable_n2", 32'(PENABLE), 32'd1);
        chk("w_ready_n2",   32'(ready), 32'd0);
        @(negedge PCLK);
        chk("w_psel_n3",    32'(PSEL), 32'h1);
        chk("w_penable_n3", 32'(PENABLE), 32'd1);
        chk("w_ready_n3",   32'(ready), 32'd1);
        @(negedge PCLK);
        chk("w_psel_n4",    32'(PSEL), 32'd0);
        settle(2);

        // Read from slave 1
        sdata[1] = 32'h0000_A5A5;
        start(1'b0, 32'h1000_1008, 32'h0, 1, 32'h0000_A5A5, 1'b0);
        @(negedge PCLK);
        chk("r_paddr", PADDR, 32'h1000_1008);
        chk("r_psel",  32'(PSEL), 32'h2);
        repeat (2) @(negedge PCLK);
        chk("r_ready_n3", 32'(ready), 32'd1);
        chk("r_rdata_n3", rdata, 32'h0000_A5A5);
        @(negedge PCLK);
        chk("r_rdata_n4", rdata, 32'd0);
        settle(2);

        // Unmapped addresses, including both edges of the window
        start(1'b0, 32'h2000_0000, 32'h0, 1, 32'h0, 1'b1);
        @(negedge PCLK);
        chk("u_psel",     32'(PSEL), 32'd0);
        chk("u_ready_n1", 32'(ready), 32'd1);
        chk("u_err_n1",   32'(err), 32'd1);
        chk("u_rdata_n1", rdata, 32'd0);
        @(negedge PCLK);
        chk("u_ready_n2", 32'(ready), 32'd0);
        start(1'b1, 32'h1000_4000, 32'h1234, 1, 32'h0, 1'b1);
        settle(2);
        start(1'b0, 32'h0FFF_FFFC, 32'h0, 1, 32'h0, 1'b1);
        settle(2);

        // Timeout on slave 2; other slaves hold PREADY high and must be ignored
        mode[0] = 3'd4; mode[1] = 3'd4; mode[2] = 3'd2; mode[3] = 3'd4;
        start(1'b0, 32'h1000_2000, 32'h0, 1, 32'h0, 1'b1);
        for (int k = 1; k <= 18; k++) begin
            @(negedge PCLK);
            if (k == 16) chk("to_ready_n16", 32'(ready), 32'd0);
            if (k == 17) begin
                chk("to_ready_n17", 32'(ready), 32'd1);
                chk("to_err_n17",   32'(err), 32'd1);
                chk("to_rdata_n17", rdata, 32'd0);
            end
            if (k == 18) chk("to_psel_n18", 32'(PSEL), 32'd0);
        end
        settle(1);

        // PREADY arriving in the last allowed cycle is a normal completion
        mode[2] = 3'd3;
        sdata[2] = 32'hCAFE_0002;
        start(1'b0, 32'h1000_2010, 32'h0, 1, 32'hCAFE_0002, 1'b0);
        repeat (17) @(negedge PCLK);
        chk("late_ready_n17", 32'(ready), 32'd1);
        chk("late_err_n17",   32'(err), 32'd0);
        settle(2);

        // Combinational slave gives minimum latency
        mode[0] = 3'd0; mode[1] = 3'd0; mode[2] = 3'd2; mode[3] = 3'd1;
        sdata[3] = 32'h1234_5678;
        start(1'b0, 32'h1000_3FFC, 32'h0, 1, 32'h1234_5678, 1'b0);
        repeat (2) @(negedge PCLK);
        chk("comb_ready_n2", 32'(ready), 32'd1);
        settle(2);

        // Back-to-back with a stray request during ACCESS
        rc0 = ready_cnt;
        start(1'b1, 32'h1000_1004, 32'h1111_1111, 1, 32'h0000_A5A5, 1'b0);
        @(posedge PCLK); #1;
        transfer = 1'b1; write = 1'b0; addr = 32'h1000_3000;
        @(posedge PCLK); #1;
        transfer = 1'b0;
        start(1'b1, 32'h1000_0010, 32'h2222_2222, 1, 32'h0, 1'b0);
        settle(6);
        chk("b2b_ready_pulses", 32'(ready_cnt - rc0), 32'd2);

        // Reset during ACCESS
        rc0 = ready_cnt;
        start(1'b0, 32'h1000_2000, 32'h0, 0, 32'h0, 1'b0);
        @(negedge PCLK);
        @(negedge PCLK);
        chk("rst_mid_penable_before", 32'(PENABLE), 32'd1);
        #2 PRESET = 1'b1;
        #1;
        chk("rst_mid_psel",    32'(PSEL), 32'd0);
        chk("rst_mid_penable", 32'(PENABLE), 32'd0);
        chk("rst_mid_paddr",   PADDR, 32'd0);
        chk("rst_mid_ready",   32'(ready), 32'd0);
        repeat (2) @(posedge PCLK);
        #1 PRESET = 1'b0;
        repeat (2) @(negedge PCLK);
        chk("rst_mid_no_pulse", 32'(ready_cnt - rc0), 32'd0);
        start(1'b1, 32'h1000_0020, 32'h3333_3333, 1, 32'h0, 1'b0);
        settle(5);
        chk("rst_after_pulse", 32'(ready_cnt - rc0), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/apb_master.md
# apb_master

APB3 bridge between the multi-cycle CPU's data-memory bus and the peripheral slaves: GPIO, UART, timer, and others. It latches a one-cycle CPU request, decodes the peripheral address window, and runs the APB SETUP/ACCESS sequence on the selected slave. It multiplexes that slave's PRDATA/PREADY back to the CPU. A timeout covers a slave that never responds, and unmapped addresses complete with an error.

## Interface
- NSLV, 4, number of slave ports; slave i owns window BASE + i*0x1000
- BASE, 32'h1000_0000, base address of the peripheral region (4 KiB aligned)
- TIMEOUT, 16, max ACCESS cycles waiting for PREADY before abort (≥2)
- PCLK  in  1  clock
- PRESET  in  1  reset, asynchronous, active-high
- transfer  in  1  CPU request strobe, sampled only in IDLE
- write  in  1  1=write, 0=read (sampled with transfer)
- addr  in  32  byte address (sampled with transfer)
- wdata  in  32  write data (sampled with transfer)
- rdata  out  32  read data, valid while ready=1
- ready  out  1  one-cycle completion pulse
- err  out  1  valid with ready; 1=unmapped or timeout
- PADDR  out  32  latched addr
- PWRITE  out  1  latched write
- PWDATA  out  32  latched wdata
- PENABLE  out  1  APB enable
- PSEL  out  NSLV  one-hot slave select
- PRDATA  in  NSLV*32  slave i read data in bits [32i+31:32i]
- PREADY  in  NSLV  slave ready

## Operation
- States: IDLE, SETUP, ACCESS, ERR.
- **IDLE:** if transfer=1, register addr, write and wdata into PADDR, PWRITE and PWDATA. Decode addr:
  - hit when addr[31:12] is in BASE[31:12] .. BASE[31:12]+NSLV-1; index = addr[31:12]-BASE[31:12].
  - On a hit, latch a one-hot select and go to SETUP.
  - Otherwise go to ERR.
  - If transfer=0, stay in IDLE.
- **SETUP:** PSEL[idx]=1, PENABLE=0, one cycle, then ACCESS.
- **ACCESS:** PSEL[idx]=1 and PENABLE=1.
  - ready = PREADY[idx] (combinational), rdata = PRDATA[idx], err=0.
  - When PREADY[idx]=1 is sampled, go to IDLE.
  - Otherwise increment the wait counter. When the counter equals TIMEOUT-1 with PREADY[idx] still 0: ready=1, err=1, rdata=0 that cycle, go to IDLE.
- **ERR:** PSEL=0, PENABLE=0, ready=1, err=1, rdata=0 for one cycle, then IDLE.
- rdata=0 and err=0 whenever ready=0. PREADY and PRDATA of unselected slaves are ignored.
- transfer outside IDLE is ignored: no queueing, no effect on the in-flight transfer.
- PADDR, PWRITE and PWDATA hold their latched values until the next accepted transfer.
- The wait counter clears on entry to SETUP. Its width is $clog2(TIMEOUT)+1.

## Timing
- Reset values:
  - state: IDLE
  - PSEL: 0, PENABLE: 0
  - PADDR: 0, PWDATA: 0, PWRITE: 0
  - ready: 0, err: 0, rdata: 0
  - counter: 0
- Reset asserted mid-transfer aborts immediately with no ready pulse. PSEL and PENABLE drop asynchronously.
- Hit, with transfer at cycle n:
  - n+1 SETUP
  - n+2 first ACCESS cycle
  - a slave with registered PREADY (asserted the cycle after PSEL&PENABLE) gives ready=1 at n+3
  - IDLE at n+4
- Minimum latency is transfer → ready in 2 cycles, for a slave with combinational PREADY.
- Unmapped: transfer at n gives ERR with ready=err=1 at n+1, and IDLE at n+2.
- Timeout: ready=err=1 in the TIMEOUT-th ACCESS cycle.
- Back-to-back: transfer=1 in the first IDLE cycle after completion is accepted; SETUP follows the next cycle.
- PREADY[idx] rising in the same cycle the counter reaches TIMEOUT-1 counts as normal completion (err=0, rdata=PRDATA[idx]).

## Test plan
- Write 0x0000_00FF to 0x1000_0000 (slave 0, GPIO CR), with PREADY registered one cycle after PSEL&PENABLE:
  - PSEL=4'b0001 at n+1..n+3; PENABLE at n+2..n+3
  - PWDATA=0xFF, PWRITE=1
  - ready=1, err=0 at n+3
- Read 0x1000_1008 (slave 1), with slave returning 0x0000_A5A5:
  - PADDR=0x1000_1008, PSEL=4'b0010
  - rdata=0x0000_A5A5 with ready at n+3; rdata=0 the next cycle
- Read 0x2000_0000 (unmapped):
  - PSEL stays 0
  - ready=1, err=1, rdata=0 at n+1
  - IDLE at n+2
- Slave 2 PREADY tied 0, TIMEOUT=16:
  - ready=1, err=1, rdata=0 exactly 16 cycles after ACCESS entry (cycle n+17)
  - PSEL cleared at n+18
- Two transfers back-to-back, the second issued in the first IDLE cycle after ready; an extra transfer pulse asserted during ACCESS:
  - the extra pulse is ignored
  - exactly two ready pulses, correct per-transfer PADDR
- PRESET asserted in ACCESS:
  - PSEL=0, PENABLE=0, PADDR=0 immediately
  - no ready pulse
  - a new transfer after release completes normally
